pwm_bank: RTL and testbench
===========================

# pwm_bank

Four-channel PWM generator that consumes the packed `config_regs` bus produced by the SPI register bank, and returns its live state on a packed `status_regs` bus for read-back through the same bank. It is the downstream stage of the register interface. It turns configured prescale, period, duty and polarity values into glitch-free PWM outputs on the design's output pins.

## Interface
Parameters:
- `NUM_CFG`, default 8: number of configuration registers on `config_regs`. Must be ≥ 8.
- `NUM_STATUS`, default 8: number of status registers on `status_regs`. Must be ≥ 3.
- `REG_WIDTH`, default 8: register width. Counter, prescaler and duty are all REG_WIDTH bits.

Ports:
- `clk`, in, 1: system clock.
- `rstb`, in, 1: reset, asynchronous, active-low.
- `ena`, in, 1: design enable. When low, all state freezes and outputs hold.
- `config_regs`, in, NUM_CFG*REG_WIDTH: packed config. Register k occupies bits [(k+1)*REG_WIDTH-1 : k*REG_WIDTH].
- `status_regs`, out, NUM_STATUS*REG_WIDTH: packed status, same packing.
- `pwm_out`, out, 4: PWM outputs, registered.
- `wrap_pulse`, out, 1: one-cycle pulse on each counter wrap, registered.

## Operation
Config map:
- reg0 CTRL:
  - bit0 GEN: global enable.
  - bit1 CLR: counter clear, level-sensitive.
  - bits[7:4] CHEN[3:0]: per-channel enable.
- reg1 PRESCALE: one tick every PRESCALE+1 clk cycles.
- reg2 PERIOD: counter runs 0..PERIOD, so the PWM period is PERIOD+1 ticks.
- reg3..reg6 DUTY0..DUTY3.
- reg7 bits[3:0] INV[3:0]: output polarity invert. Bits[7:4] are ignored.

Prescaler `pre_cnt`:
- Increments each enabled cycle.
- `tick` is asserted when `pre_cnt` ≥ PRESCALE; `pre_cnt` then returns to 0.

Counter `cnt`:
- On `tick`: if `cnt` ≥ `period_eff`, then `cnt` ← 0, `wrap_pulse` ← 1 and `wrap_cnt`++. Otherwise `cnt`++.
- The `≥` compare means that lowering PERIOD below the current `cnt` forces a wrap on the next tick.

Channel i:
- `raw = (cnt < duty_eff[i]) ^ INV[i]`.
- `pwm_out[i] ← GEN & CHEN[i] & raw`. A disabled channel drives 0 regardless of INV.
- DUTY=0 gives always low (before invert).
- DUTY > PERIOD gives always high.

GEN=0:
- `pre_cnt`, `cnt` and `wrap_pulse` are held at 0 and `wrap_cnt` holds its value.
- All `pwm_out` are 0.
- Shadows (see Configuration) load continuously.

CLR=1 with GEN=1:
- `pre_cnt` and `cnt` are held at 0. No ticks and no wraps occur.
- Channel outputs are still computed against `cnt`=0.

Status map:
- status0 = `cnt`.
- status1 = `wrap_cnt`, 8-bit, wraps 255→0.
- status2 = {0, `pwm_out[3:0]`}.
- status3 onwards = 0.

`ena`=0: every register holds its value, including `wrap_pulse` (not forced low).

Reset (`rstb`=0) clears all registers. Outputs are 0: `pwm_out`=0, `wrap_pulse`=0 and `status_regs`=0. Asserting reset mid-period aborts immediately, with no pending wrap.

## Timing
- `pwm_out` and `wrap_pulse` are registered, with 1 clk of latency after the `cnt`/tick state that produced them.
- With PRESCALE=0, a tick occurs every enabled cycle.
- A config change takes effect on the first clk edge after `config_regs` changes, or at the next wrap when shadowing is enabled.
- On a 0→1 edge of GEN, the first tick is PRESCALE+1 cycles later.
- The first `pwm_out` update is 1 cycle after GEN rises.

## Configuration
Macro `PWM_SHADOW_EN`.
- Defined:
  - `period_eff` and `duty_eff[3:0]` are shadow registers.
  - They load from PERIOD/DUTY on the cycle the wrap occurs, and continuously while GEN=0 or CLR=1.
  - Mid-period writes never alter the current period.
- Undefined:
  - `period_eff` = PERIOD and `duty_eff` = DUTY directly, with no shadow flops.
  - Writes apply immediately, which may create short or long pulses.

## Structure
- Package `pwm_pkg` holds:
  - Register index localparams: `CTRL_IDX`, `PRESCALE_IDX`, `PERIOD_IDX`, `DUTY0_IDX`, `INV_IDX`.
  - Status indices.
  - CTRL bit positions: `GEN_BIT`, `CLR_BIT`, `CHEN_LSB`.
  - `NUM_CH`=4.
- Sub-module `pwm_channel`, instantiated 4×: duty shadow, compare, invert, enable gating and output flop.
- Top level: prescaler, counter, wrap counter, period shadow and status packing.

## Test plan
1. Reset with all config=0 → `pwm_out`=0, `wrap_pulse`=0, `status_regs`=0. Setting GEN=1 alone leaves `pwm_out`=0.
2. PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=0x11 → `pwm_out[0]` is high 3 of every 10 clks. `wrap_pulse` fires every 10 clks. status1 increments by 1 per wrap.
3. PRESCALE=3, PERIOD=4, DUTY1=0xFF, INV1=1, CTRL=0x21 → `pwm_out[1]` stays 0. `cnt` advances every 4 clks and `wrap_pulse` fires every 20 clks.
4. PERIOD=99 running; at `cnt`=50, write PERIOD=20 and DUTY0=10.
   - Shadow defined: the current period completes at 100 ticks, then the new 21-tick period begins with duty 10.
   - Shadow undefined: a wrap occurs on the next tick.
5. Toggle CLR=1 for 5 clks mid-period → `cnt` reads 0 throughout with no `wrap_pulse`. Release → counting resumes from 0.
6. Hold `ena`=0 for 10 clks mid-period → `pwm_out`, status and `wrap_pulse` are frozen. Assert `rstb` mid-period → all outputs are 0 asynchronously.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared register map, status map and channel count for the pwm_bank block.
// Optional duty/period shadowing is selected with the PWM_SHADOW_EN macro.
package pwm_pkg;
    localparam int NUM_CH       = 4;

    // Config register indices
    localparam int CTRL_IDX     = 0;
    localparam int PRESCALE_IDX = 1;
    localparam int PERIOD_IDX   = 2;
    localparam int DUTY0_IDX    = 3;
    localparam int INV_IDX      = 7;

    // Status register indices
    localparam int STAT_CNT_IDX  = 0;
    localparam int STAT_WRAP_IDX = 1;
    localparam int STAT_PWM_IDX  = 2;

    // CTRL bit positions
    localparam int GEN_BIT  = 0;
    localparam int CLR_BIT  = 1;
    localparam int CHEN_LSB = 4;
endpackage

// File: rtl/pwm_bank_if.sv
// Packed config/status register bus between the SPI register bank and pwm_bank.
interface pwm_bank_if #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8
);
    logic [NUM_CFG*REG_WIDTH-1:0]    config_regs;
    logic [NUM_STATUS*REG_WIDTH-1:0] status_regs;

    modport master (output config_regs, input  status_regs);
    modport slave  (input  config_regs, output status_regs);
endinterface

// File: rtl/pwm_bank_channel.sv
// One PWM channel: optional duty shadow, compare against the shared counter,
// polarity invert, enable gating and the output flop.
module pwm_channel #(
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 ld_sh,
    input  logic                 gen,
    input  logic                 chen,
    input  logic                 inv,
    input  logic [REG_WIDTH-1:0] cnt,
    input  logic [REG_WIDTH-1:0] duty,
    output logic                 pwm
);
    logic [REG_WIDTH-1:0] duty_eff;
    logic                 raw;

`ifdef PWM_SHADOW_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            duty_eff <= '0;
        else if (ena && ld_sh)
            duty_eff <= duty;
    end
`else
    logic unused_ld;
    assign unused_ld = ld_sh;
    assign duty_eff  = duty;
`endif

    // Invert is applied before gating so a disabled channel is always low.
    assign raw = (cnt < duty_eff) ^ inv;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            pwm <= 1'b0;
        else if (ena)
            pwm <= gen & chen & raw;
    end
endmodule

// File: rtl/pwm_bank.sv
// Four-channel PWM bank: prescaler, shared period counter, wrap counter and
// status packing. Define PWM_SHADOW_EN to make period/duty updates wrap-aligned.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    pwm_bank_if.slave         bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              wrap_pulse
);
    logic [NUM_CFG-1:0][REG_WIDTH-1:0] cfg;
    logic [REG_WIDTH-1:0]              prescale, period, period_eff;
    logic [REG_WIDTH-1:0]              pre_cnt, cnt;
    logic [7:0]                        wrap_cnt;
    logic [NUM_CH-1:0]                 chen, inv;
    logic                              gen, clr, run, tick, wrap, ld_sh;
    logic                              unused_cfg;

    assign cfg      = bus.config_regs;
    assign gen      = cfg[CTRL_IDX][GEN_BIT];
    assign clr      = cfg[CTRL_IDX][CLR_BIT];
    assign chen     = cfg[CTRL_IDX][CHEN_LSB +: NUM_CH];
    assign prescale = cfg[PRESCALE_IDX];
    assign period   = cfg[PERIOD_IDX];
    assign inv      = cfg[INV_IDX][NUM_CH-1:0];
    // Reserved CTRL/INV bits and any extra config registers are ignored.
    assign unused_cfg = ^bus.config_regs;

    assign run   = gen & ~clr;
    assign tick  = run & (pre_cnt >= prescale);
    assign wrap  = tick & (cnt >= period_eff);
    assign ld_sh = ~gen | clr | wrap;

`ifdef PWM_SHADOW_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            period_eff <= '0;
        else if (ena && ld_sh)
            period_eff <= period;
    end
`else
    assign period_eff = period;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pre_cnt    <= '0;
            cnt        <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else if (ena) begin
            pre_cnt    <= (!run || tick) ? '0 : pre_cnt + REG_WIDTH'(1);
            // >= lets a lowered PERIOD force a wrap on the next tick.
            if (!run || wrap)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + REG_WIDTH'(1);
            wrap_pulse <= wrap;
            if (wrap)
                wrap_cnt <= wrap_cnt + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(.REG_WIDTH(REG_WIDTH)) u_ch (
            .clk   (clk),
            .rstb  (rstb),
            .ena   (ena),
            .ld_sh (ld_sh),
            .gen   (gen),
            .chen  (chen[g]),
            .inv   (inv[g]),
            .cnt   (cnt),
            .duty  (cfg[DUTY0_IDX+g]),
            .pwm   (pwm_out[g])
        );
    end

    always_comb begin
        bus.status_regs = '0;
        bus.status_regs[STAT_CNT_IDX*REG_WIDTH  +: REG_WIDTH] = cnt;
        bus.status_regs[STAT_WRAP_IDX*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'(wrap_cnt);
        bus.status_regs[STAT_PWM_IDX*REG_WIDTH  +: REG_WIDTH] = REG_WIDTH'(pwm_out);
    end
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: reset, duty/period counting, prescale, invert,
// mid-period reprogramming, clear, enable freeze and asynchronous reset.
module tb_pwm_bank;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic [3:0] pwm_out;
    logic       wrap_pulse;
    int         checks = 0;
    int         errors = 0;
    int         hi0, hi1, wr;

    pwm_bank_if #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) bus ();

    pwm_bank #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .ena        (ena),
        .bus        (bus),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setr(input int idx, input logic [7:0] v);
        bus.config_regs[idx*8 +: 8] = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st(input int idx);
        return bus.status_regs[idx*8 +: 8];
    endfunction

    initial begin
        rstb = 1'b0;
        ena  = 1'b1;
        bus.config_regs = '0;
        #3;
        check("rst_pwm",    64'(pwm_out), 64'h0);
        check("rst_wrap",   64'(wrap_pulse), 64'h0);
        check("rst_status", bus.status_regs, 64'h0);
        step(1);
        rstb = 1'b1;

        // GEN alone: no channel enabled; PERIOD=0 wraps on every tick
        setr(CTRL_IDX, 8'h01);
        step(3);
        check("gen_only_pwm",  64'(pwm_out), 64'h0);
        check("gen_only_wcnt", 64'(st(1)), 64'd3);
        check("gen_only_wrap", 64'(wrap_pulse), 64'h1);

        // PRESCALE=0, PERIOD=9, DUTY0=3
        setr(CTRL_IDX, 8'h00);
        setr(PRESCALE_IDX, 8'd0);
        setr(PERIOD_IDX, 8'd9);
        setr(DUTY0_IDX, 8'd3);
        step(1);
        check("idle_wrap", 64'(wrap_pulse), 64'h0);
        setr(CTRL_IDX, 8'h11);
        hi0 = 0; wr = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (i == 0) begin
                check("p2_first_cnt", 64'(st(0)), 64'd1);
                check("p2_first_pwm", 64'(pwm_out), 64'h1);
            end
            hi0 += int'(pwm_out[0]);
            wr  += int'(wrap_pulse);
        end
        check("p2_hi_a",   64'(hi0), 64'd3);
        check("p2_wr_a",   64'(wr), 64'd1);
        check("p2_wcnt_a", 64'(st(1)), 64'd4);
        check("p2_cnt_a",  64'(st(0)), 64'd0);
        hi0 = 0; wr = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            hi0 += int'(pwm_out[0]);
            wr  += int'(wrap_pulse);
        end
        check("p2_hi_b",   64'(hi0), 64'd3);
        check("p2_wr_b",   64'(wr), 64'd1);
        check("p2_wcnt_b", 64'(st(1)), 64'd5);

        // ena=0 freezes everything, including a high wrap_pulse
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("frz_wrap",   64'(wrap_pulse), 64'h1);
            check("frz_status", bus.status_regs, 64'h0000_0000_0000_0500);
        end
        ena = 1'b1;
        step(1);
        check("unfrz_wrap",   64'(wrap_pulse), 64'h0);
        check("unfrz_status", bus.status_regs, 64'h0000_0000_0001_0501);

        // PRESCALE=3, PERIOD=4, DUTY1=FF inverted, channels 0 and 1
        setr(CTRL_IDX, 8'h00);
        setr(PRESCALE_IDX, 8'd3);
        setr(PERIOD_IDX, 8'd4);
        setr(DUTY0_IDX + 1, 8'hFF);
        setr(INV_IDX, 8'h02);
        step(1);
        setr(CTRL_IDX, 8'h31);
        hi0 = 0; hi1 = 0; wr = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 3) check("p3_cnt_e3", 64'(st(0)), 64'd0);
            if (i == 4) check("p3_cnt_e4", 64'(st(0)), 64'd1);
            if (i == 8) check("p3_cnt_e8", 64'(st(0)), 64'd2);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            wr  += int'(wrap_pulse);
        end
        check("p3_hi0", 64'(hi0), 64'd24);
        check("p3_hi1", 64'(hi1), 64'd0);
        check("p3_wr",  64'(wr), 64'd2);
        check("p3_wcnt", 64'(st(1)), 64'd7);
        check("p3_wrap_e40", 64'(wrap_pulse), 64'h1);

        // CLR held 5 cycles mid-period
        step(9);
        check("clr_pre_cnt", 64'(st(0)), 64'd2);
        setr(CTRL_IDX, 8'h33);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("clr_cnt",  64'(st(0)), 64'd0);
            check("clr_wrap", 64'(wrap_pulse), 64'h0);
            check("clr_pwm",  64'(pwm_out), 64'h1);
        end
        setr(CTRL_IDX, 8'h31);
        step(3);
        check("clr_rel_e3", 64'(st(0)), 64'd0);
        step(1);
        check("clr_rel_e4", 64'(st(0)), 64'd1);

        // PERIOD=99 running, reprogram at cnt=50
        setr(CTRL_IDX, 8'h00);
        setr(PRESCALE_IDX, 8'd0);
        setr(PERIOD_IDX, 8'd99);
        setr(DUTY0_IDX, 8'd40);
        step(1);
        setr(CTRL_IDX, 8'h11);
        step(50);
        check("p4_cnt50", 64'(st(0)), 64'd50);
        setr(PERIOD_IDX, 8'd20);
        setr(DUTY0_IDX, 8'd10);
        step(1);
`ifdef PWM_SHADOW_EN
        check("p4_sh_cnt51",  64'(st(0)), 64'd51);
        check("p4_sh_wrap51", 64'(wrap_pulse), 64'h0);
        step(48);
        check("p4_sh_cnt99",  64'(st(0)), 64'd99);
        step(1);
`endif
        check("p4_wrap_cnt", 64'(st(0)), 64'd0);
        check("p4_wrap",     64'(wrap_pulse), 64'h1);
        check("p4_wcnt",     64'(st(1)), 64'd8);
        hi0 = 0; wr = 0;
        for (int i = 0; i < 21; i++) begin
            step(1);
            hi0 += int'(pwm_out[0]);
            wr  += int'(wrap_pulse);
        end
        check("p4_new_hi",  64'(hi0), 64'd10);
        check("p4_new_wr",  64'(wr), 64'd1);
        check("p4_new_cnt", 64'(st(0)), 64'd0);

        // asynchronous reset mid-period
        step(5);
        check("pre_rst_pwm", 64'(pwm_out), 64'h1);
        #2 rstb = 1'b0;
        #1;
        check("arst_pwm",    64'(pwm_out), 64'h0);
        check("arst_wrap",   64'(wrap_pulse), 64'h0);
        check("arst_status", bus.status_regs, 64'h0);
        step(2);
        check("hold_rst_status", bus.status_regs, 64'h0);
        rstb = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
